// File: rtl/stg_ma.sv
// stg_ma: memory-access stage. Registers the EX bundle, runs the data-memory
// req/gnt/rvalid handshake for loads/stores, and reports bus errors/timeouts.
module stg_ma #(
  parameter int TIMEOUT     = 64,
  parameter int HBIT_ADDR   = 47,
  parameter int HBIT_DATA   = 23,
  parameter int HBIT_OPC    = 5,
  parameter int HBIT_TGT_GP = 3,
  parameter int HBIT_TGT_SR = 1,
  parameter int HBIT_TGT_AR = 1
) (
  input  logic                   iw_clk,
  input  logic                   iw_rst_n,
  input  logic [HBIT_ADDR:0]     iw_pc,
  input  logic [HBIT_DATA:0]     iw_instr,
  input  logic [HBIT_OPC:0]      iw_opc,
  input  logic                   iw_mem_rd,
  input  logic                   iw_mem_wr,
  input  logic [HBIT_ADDR:0]     iw_addr,
  input  logic [HBIT_DATA:0]     iw_result,
  input  logic [HBIT_ADDR:0]     iw_ar_result,
  input  logic [HBIT_ADDR:0]     iw_sr_result,
  input  logic [HBIT_TGT_GP:0]   iw_tgt_gp,
  input  logic                   iw_tgt_gp_we,
  input  logic [HBIT_TGT_SR:0]   iw_tgt_sr,
  input  logic                   iw_tgt_sr_we,
  input  logic [HBIT_TGT_AR:0]   iw_tgt_ar,
  input  logic                   iw_tgt_ar_we,
  input  logic                   iw_flush,
  input  logic                   iw_stall,
  output logic                   ow_stall_req,
  output logic                   ow_dmem_req,
  output logic                   ow_dmem_we,
  output logic [HBIT_ADDR:0]     ow_dmem_addr,
  output logic [HBIT_DATA:0]     ow_dmem_wdata,
  input  logic                   iw_dmem_gnt,
  input  logic                   iw_dmem_rvalid,
  input  logic [HBIT_DATA:0]     iw_dmem_rdata,
  input  logic                   iw_dmem_err,
  output logic [HBIT_ADDR:0]     ow_pc,
  output logic [HBIT_DATA:0]     ow_instr,
  output logic [HBIT_OPC:0]      ow_opc,
  output logic [HBIT_DATA:0]     ow_result,
  output logic [HBIT_ADDR:0]     ow_ar_result,
  output logic [HBIT_ADDR:0]     ow_sr_result,
  output logic [HBIT_TGT_GP:0]   ow_tgt_gp,
  output logic                   ow_tgt_gp_we,
  output logic [HBIT_TGT_SR:0]   ow_tgt_sr,
  output logic                   ow_tgt_sr_we,
  output logic [HBIT_TGT_AR:0]   ow_tgt_ar,
  output logic                   ow_tgt_ar_we,
  output logic                   ow_fault,
  output logic [HBIT_ADDR:0]     ow_fault_pc,
  output logic [HBIT_ADDR:0]     ow_fault_addr
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  // 9 bits so the increment past 255 cannot wrap below TIMEOUT
  localparam logic [8:0] TMO = 9'(TIMEOUT);

  state_t r_state, w_state_nxt;
  logic [7:0] r_cnt;
  logic [8:0] w_cnt_inc;
  logic       w_tmo;
  logic       w_cap_pass, w_cap_mem, w_done, w_buf, w_hold_done, w_fault;
  logic       w_from_slot;
  logic [HBIT_DATA:0] w_rsp, w_res;

  // latched memory slot
  logic [HBIT_ADDR:0]   r_pc, r_addr, r_ar, r_sr;
  logic [HBIT_DATA:0]   r_instr, r_wdata, r_rsp;
  logic [HBIT_OPC:0]    r_opc;
  logic                 r_we;
  logic [HBIT_TGT_GP:0] r_tgt_gp;
  logic [HBIT_TGT_SR:0] r_tgt_sr;
  logic [HBIT_TGT_AR:0] r_tgt_ar;
  logic                 r_gp_we, r_sr_we, r_ar_we;

  // registered writeback bundle and fault report
  logic [HBIT_ADDR:0]   r_o_pc, r_o_ar, r_o_sr, r_fault_pc, r_fault_addr;
  logic [HBIT_DATA:0]   r_o_instr, r_o_result;
  logic [HBIT_OPC:0]    r_o_opc;
  logic [HBIT_TGT_GP:0] r_o_tgt_gp;
  logic [HBIT_TGT_SR:0] r_o_tgt_sr;
  logic [HBIT_TGT_AR:0] r_o_tgt_ar;
  logic                 r_o_gp_we, r_o_sr_we, r_o_ar_we, r_fault;

  assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;
  assign w_tmo     = (w_cnt_inc >= TMO);
  // store completes with its own data, load with the bus data
  assign w_rsp       = r_we ? r_wdata : iw_dmem_rdata;
  assign w_from_slot = w_done | w_hold_done;
  assign w_res       = w_hold_done ? r_rsp : w_rsp;

  // Next-state and per-cycle action decode; response/grant win over timeout
  always_comb begin
    w_state_nxt = r_state;
    w_cap_pass  = 1'b0;
    w_cap_mem   = 1'b0;
    w_done      = 1'b0;
    w_buf       = 1'b0;
    w_hold_done = 1'b0;
    w_fault     = 1'b0;
    case (r_state)
      S_IDLE: if (!iw_stall) begin
        if (!iw_flush && (iw_mem_rd || iw_mem_wr)) begin
          w_cap_mem   = 1'b1;
          w_state_nxt = S_REQ;
        end else begin
          w_cap_pass = 1'b1;
        end
      end
      S_REQ: begin
        if (iw_dmem_gnt) w_state_nxt = S_WAIT;
        else if (w_tmo) begin
          w_fault     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (iw_dmem_rvalid) begin
          if (iw_dmem_err) begin
            w_fault     = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (iw_stall) begin
            w_buf       = 1'b1;
            w_state_nxt = S_HOLD;
          end else begin
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else if (w_tmo) begin
          w_fault     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_HOLD: if (!iw_stall) begin
        w_hold_done = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register and busy counter (counts only while REQ/WAIT)
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_REQ || r_state == S_WAIT) r_cnt <= w_cnt_inc[7:0];
      else                                       r_cnt <= '0;
    end
  end

  // Slot latch, response buffer, writeback bundle and fault report
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      {r_pc, r_addr, r_ar, r_sr, r_instr, r_wdata, r_rsp, r_opc, r_we} <= '0;
      {r_tgt_gp, r_tgt_sr, r_tgt_ar, r_gp_we, r_sr_we, r_ar_we}       <= '0;
      {r_o_pc, r_o_ar, r_o_sr, r_o_instr, r_o_result, r_o_opc}         <= '0;
      {r_o_tgt_gp, r_o_tgt_sr, r_o_tgt_ar}                             <= '0;
      {r_o_gp_we, r_o_sr_we, r_o_ar_we}                                <= '0;
      {r_fault, r_fault_pc, r_fault_addr}                              <= '0;
    end else begin
      r_fault <= 1'b0;
      if (w_cap_pass) begin
        r_o_pc     <= iw_pc;
        r_o_instr  <= iw_instr;
        r_o_opc    <= iw_opc;
        r_o_result <= iw_result;
        r_o_ar     <= iw_ar_result;
        r_o_sr     <= iw_sr_result;
        r_o_tgt_gp <= iw_tgt_gp;
        r_o_tgt_sr <= iw_tgt_sr;
        r_o_tgt_ar <= iw_tgt_ar;
        r_o_gp_we  <= iw_tgt_gp_we & ~iw_flush;
        r_o_sr_we  <= iw_tgt_sr_we & ~iw_flush;
        r_o_ar_we  <= iw_tgt_ar_we & ~iw_flush;
      end
      if (w_cap_mem) begin
        r_pc     <= iw_pc;
        r_instr  <= iw_instr;
        r_opc    <= iw_opc;
        r_addr   <= iw_addr;
        r_we     <= iw_mem_wr;
        r_wdata  <= iw_result;
        r_ar     <= iw_ar_result;
        r_sr     <= iw_sr_result;
        r_tgt_gp <= iw_tgt_gp;
        r_tgt_sr <= iw_tgt_sr;
        r_tgt_ar <= iw_tgt_ar;
        r_gp_we  <= iw_tgt_gp_we;
        r_sr_we  <= iw_tgt_sr_we;
        r_ar_we  <= iw_tgt_ar_we;
        {r_o_gp_we, r_o_sr_we, r_o_ar_we} <= '0;
      end
      if (w_buf) r_rsp <= w_rsp;
      if (w_from_slot) begin
        r_o_pc     <= r_pc;
        r_o_instr  <= r_instr;
        r_o_opc    <= r_opc;
        r_o_result <= w_res;
        r_o_ar     <= r_ar;
        r_o_sr     <= r_sr;
        r_o_tgt_gp <= r_tgt_gp;
        r_o_tgt_sr <= r_tgt_sr;
        r_o_tgt_ar <= r_tgt_ar;
        r_o_gp_we  <= r_gp_we;
        r_o_sr_we  <= r_sr_we;
        r_o_ar_we  <= r_ar_we;
      end
      if (w_fault) begin
        r_fault      <= 1'b1;
        r_fault_pc   <= r_pc;
        r_fault_addr <= r_addr;
        {r_o_gp_we, r_o_sr_we, r_o_ar_we} <= '0;
      end
    end
  end

  assign ow_stall_req  = (r_state != S_IDLE);
  assign ow_dmem_req   = (r_state == S_REQ);
  assign ow_dmem_we    = r_we;
  assign ow_dmem_addr  = r_addr;
  assign ow_dmem_wdata = r_wdata;
  assign ow_pc         = r_o_pc;
  assign ow_instr      = r_o_instr;
  assign ow_opc        = r_o_opc;
  assign ow_result     = r_o_result;
  assign ow_ar_result  = r_o_ar;
  assign ow_sr_result  = r_o_sr;
  assign ow_tgt_gp     = r_o_tgt_gp;
  assign ow_tgt_gp_we  = r_o_gp_we;
  assign ow_tgt_sr     = r_o_tgt_sr;
  assign ow_tgt_sr_we  = r_o_sr_we;
  assign ow_tgt_ar     = r_o_tgt_ar;
  assign ow_tgt_ar_we  = r_o_ar_we;
  assign ow_fault      = r_fault;
  assign ow_fault_pc   = r_fault_pc;
  assign ow_fault_addr = r_fault_addr;

endmodule

// File: tb/tb_stg_ma.sv
// tb_stg_ma: directed checks of pass-through, load, store, stall/HOLD,
// timeout, bus error, flush and asynchronous reset.
module tb_stg_ma;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic [47:0] pc, addr, ar_res, sr_res;
  logic [23:0] instr, result, rdata;
  logic [5:0]  opc;
  logic        mem_rd, mem_wr, flush, stall, gnt, rvalid, err;
  logic [3:0]  tgt_gp;
  logic [1:0]  tgt_sr, tgt_ar;
  logic        gp_we, sr_we, ar_we;
  logic        o_stall_req, o_req, o_we, o_fault;
  logic [47:0] o_addr, o_pc, o_ar, o_sr, o_fpc, o_faddr;
  logic [23:0] o_wdata, o_instr, o_result;
  logic [5:0]  o_opc;
  logic [3:0]  o_tgt_gp;
  logic [1:0]  o_tgt_sr, o_tgt_ar;
  logic        o_gp_we, o_sr_we, o_ar_we;
  int nerr = 0, nchk = 0;

  always #5 clk = ~clk;

  stg_ma #(.TIMEOUT(64)) dut (
    .iw_clk(clk), .iw_rst_n(rst_n), .iw_pc(pc), .iw_instr(instr), .iw_opc(opc),
    .iw_mem_rd(mem_rd), .iw_mem_wr(mem_wr), .iw_addr(addr), .iw_result(result),
    .iw_ar_result(ar_res), .iw_sr_result(sr_res),
    .iw_tgt_gp(tgt_gp), .iw_tgt_gp_we(gp_we), .iw_tgt_sr(tgt_sr), .iw_tgt_sr_we(sr_we),
    .iw_tgt_ar(tgt_ar), .iw_tgt_ar_we(ar_we), .iw_flush(flush), .iw_stall(stall),
    .ow_stall_req(o_stall_req), .ow_dmem_req(o_req), .ow_dmem_we(o_we),
    .ow_dmem_addr(o_addr), .ow_dmem_wdata(o_wdata),
    .iw_dmem_gnt(gnt), .iw_dmem_rvalid(rvalid), .iw_dmem_rdata(rdata), .iw_dmem_err(err),
    .ow_pc(o_pc), .ow_instr(o_instr), .ow_opc(o_opc), .ow_result(o_result),
    .ow_ar_result(o_ar), .ow_sr_result(o_sr),
    .ow_tgt_gp(o_tgt_gp), .ow_tgt_gp_we(o_gp_we), .ow_tgt_sr(o_tgt_sr), .ow_tgt_sr_we(o_sr_we),
    .ow_tgt_ar(o_tgt_ar), .ow_tgt_ar_we(o_ar_we),
    .ow_fault(o_fault), .ow_fault_pc(o_fpc), .ow_fault_addr(o_faddr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one edge; inputs change and outputs are sampled 1 time unit later
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // upstream bubble: nothing memory-related, no writes
  task automatic idle_in();
    pc = '0; instr = '0; opc = '0; addr = '0; result = '0; ar_res = '0; sr_res = '0;
    mem_rd = 0; mem_wr = 0; flush = 0; tgt_gp = '0; tgt_sr = '0; tgt_ar = '0;
    gp_we = 0; sr_we = 0; ar_we = 0;
  endtask

  initial begin
    idle_in();
    stall = 0; gnt = 0; rvalid = 0; err = 0; rdata = '0;

    // reset state
    #2;
    chk("rst_stall_req", 64'(o_stall_req), 0);
    chk("rst_dmem_req",  64'(o_req), 0);
    chk("rst_fault",     64'(o_fault), 0);
    chk("rst_gp_we",     64'(o_gp_we), 0);
    chk("rst_result",    64'(o_result), 0);
    tick(); tick();
    rst_n = 1;

    // ALU pass-through
    result = 24'h123456; tgt_gp = 4'd3; gp_we = 1;
    tick();
    chk("alu_result",    64'(o_result), 64'h123456);
    chk("alu_tgt_gp",    64'(o_tgt_gp), 3);
    chk("alu_gp_we",     64'(o_gp_we), 1);
    chk("alu_dmem_req",  64'(o_req), 0);
    chk("alu_stall_req", 64'(o_stall_req), 0);
    idle_in();

    // load: grant 2 cycles late, rvalid 3 cycles after grant
    pc = 48'h100; mem_rd = 1; addr = 48'h001000; tgt_gp = 4'd5; gp_we = 1;
    tick();
    idle_in();
    chk("ld_req",       64'(o_req), 1);
    chk("ld_we",        64'(o_we), 0);
    chk("ld_addr",      64'(o_addr), 64'h001000);
    chk("ld_stall",     64'(o_stall_req), 1);
    chk("ld_bubble_we", 64'(o_gp_we), 0);
    tick();
    chk("ld_req_hold1", 64'(o_req), 1);
    tick();
    chk("ld_req_hold2", 64'(o_req), 1);
    chk("ld_addr_hold", 64'(o_addr), 64'h001000);
    gnt = 1;
    tick();
    gnt = 0;
    chk("ld_req_drop",  64'(o_req), 0);
    chk("ld_stall_w0",  64'(o_stall_req), 1);
    tick();
    chk("ld_stall_w1",  64'(o_stall_req), 1);
    tick();
    chk("ld_stall_w2",  64'(o_stall_req), 1);
    rvalid = 1; rdata = 24'hABCDEF;
    tick();
    rvalid = 0; rdata = '0;
    chk("ld_result",    64'(o_result), 64'hABCDEF);
    chk("ld_gp_we",     64'(o_gp_we), 1);
    chk("ld_tgt_gp",    64'(o_tgt_gp), 5);
    chk("ld_pc",        64'(o_pc), 64'h100);
    chk("ld_stall_end", 64'(o_stall_req), 0);
    chk("ld_fault",     64'(o_fault), 0);

    // store
    mem_wr = 1; addr = 48'h002000; result = 24'h55AA55;
    tick();
    idle_in();
    chk("st_req",   64'(o_req), 1);
    chk("st_we",    64'(o_we), 1);
    chk("st_wdata", 64'(o_wdata), 64'h55AA55);
    chk("st_addr",  64'(o_addr), 64'h002000);
    gnt = 1;
    tick();
    gnt = 0; rvalid = 1;
    tick();
    rvalid = 0;
    chk("st_result", 64'(o_result), 64'h55AA55);
    chk("st_fault",  64'(o_fault), 0);
    chk("st_stall",  64'(o_stall_req), 0);

    // completion under stall: HOLD, outputs frozen until stall drops
    mem_rd = 1; addr = 48'h003000; tgt_gp = 4'd7; gp_we = 1;
    tick();
    idle_in();
    gnt = 1;
    tick();
    gnt = 0; stall = 1; rvalid = 1; rdata = 24'h000042;
    tick();
    rvalid = 0; rdata = '0;
    chk("hold_stall_req", 64'(o_stall_req), 1);
    chk("hold_frozen0",   64'(o_result), 64'h55AA55);
    chk("hold_we0",       64'(o_gp_we), 0);
    tick();
    chk("hold_frozen1",   64'(o_result), 64'h55AA55);
    tick();
    chk("hold_frozen2",   64'(o_result), 64'h55AA55);
    chk("hold_stall_req2",64'(o_stall_req), 1);
    stall = 0;
    tick();
    chk("hold_result",    64'(o_result), 64'h000042);
    chk("hold_gp_we",     64'(o_gp_we), 1);
    chk("hold_stall_end", 64'(o_stall_req), 0);

    // timeout: grant given, no response; fault at the 64th busy edge
    pc = 48'h200; mem_rd = 1; addr = 48'h004000; gp_we = 1;
    tick();
    idle_in();
    gnt = 1;
    tick();
    gnt = 0;
    for (int i = 0; i < 62; i++) tick();
    chk("tmo_nofault_early", 64'(o_fault), 0);
    chk("tmo_still_busy",    64'(o_stall_req), 1);
    tick();
    chk("tmo_fault",      64'(o_fault), 1);
    chk("tmo_fault_addr", 64'(o_faddr), 64'h004000);
    chk("tmo_fault_pc",   64'(o_fpc), 64'h200);
    chk("tmo_gp_we",      64'(o_gp_we), 0);
    chk("tmo_stall_req",  64'(o_stall_req), 0);
    tick();
    chk("tmo_pulse_end",  64'(o_fault), 0);
    chk("tmo_addr_kept",  64'(o_faddr), 64'h004000);
    rvalid = 1; rdata = 24'h000777;
    tick();
    rvalid = 0; rdata = '0;
    chk("late_rv_result", 64'(o_result), 0);
    chk("late_rv_stall",  64'(o_stall_req), 0);
    chk("late_rv_fault",  64'(o_fault), 0);

    // bus error
    pc = 48'h300; mem_rd = 1; addr = 48'h005000; gp_we = 1;
    tick();
    idle_in();
    gnt = 1;
    tick();
    gnt = 0; rvalid = 1; err = 1; rdata = 24'h000999;
    tick();
    rvalid = 0; err = 0; rdata = '0;
    chk("err_fault",      64'(o_fault), 1);
    chk("err_fault_addr", 64'(o_faddr), 64'h005000);
    chk("err_fault_pc",   64'(o_fpc), 64'h300);
    chk("err_gp_we",      64'(o_gp_we), 0);
    chk("err_stall_req",  64'(o_stall_req), 0);

    // flush on a memory slot: bubble, no request
    mem_rd = 1; flush = 1; gp_we = 1; result = 24'h000009; addr = 48'h00A000;
    tick();
    idle_in();
    chk("flush_req",    64'(o_req), 0);
    chk("flush_stall",  64'(o_stall_req), 0);
    chk("flush_gp_we",  64'(o_gp_we), 0);
    chk("flush_result", 64'(o_result), 64'h000009);

    // asynchronous reset mid-WAIT
    result = 24'h000011; gp_we = 1;
    tick();
    idle_in();
    mem_rd = 1; addr = 48'h006000;
    tick();
    idle_in();
    gnt = 1;
    tick();
    gnt = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_stall_req", 64'(o_stall_req), 0);
    chk("arst_dmem_req",  64'(o_req), 0);
    chk("arst_dmem_addr", 64'(o_addr), 0);
    chk("arst_result",    64'(o_result), 0);
    chk("arst_gp_we",     64'(o_gp_we), 0);
    tick();
    rst_n = 1; rvalid = 1; rdata = 24'h000888;
    tick();
    rvalid = 0; rdata = '0;
    chk("arst_rv_result", 64'(o_result), 0);
    chk("arst_rv_stall",  64'(o_stall_req), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
